vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back-porch pixels.
REQ-005 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, in lines.
REQ-006 SHALL have parameter HS_POL, default 0, active sync level for HS (0 = active-low).
REQ-007 SHALL have parameter VS_POL, default 0, active sync level for VS.
REQ-008 SHALL have parameter PIPE_DELAY, default 0, range 0..7, extra cycles applied to all control outputs.
REQ-009 SHALL have parameter CW, default 11, counter width; CW must hold H_TOTAL-1 and V_TOTAL-1.
REQ-010 SHALL have port VGA_CLK, input, 1, pixel clock.
REQ-011 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-012 SHALL have port enable, input, 1, advance timing when high.
REQ-013 SHALL have ports x and y, output, CW each, current pixel column and row.
REQ-014 SHALL have port displayArea, output, 1, high inside the active region.
REQ-015 SHALL have ports VGA_HS and VGA_VS, output, 1 each, sync outputs at the configured polarity.
REQ-016 SHALL have port VGA_BLANK_N, output, 1, equal to displayArea.
REQ-017 SHALL have port line_start, output, 1, one-cycle pulse for x==0.
REQ-018 SHALL have port frame_start, output, 1, one-cycle pulse for x==0 and y==0.
REQ-019 SHALL have port frame_count, output, 8, frames completed, modulo 256.

Function
REQ-020 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
REQ-021 SHALL, when enable=1, step x by 1 each cycle and wrap H_TOTAL-1 -> 0.
REQ-022 SHALL step y only on the x wrap and wrap V_TOTAL-1 -> 0.
REQ-023 SHALL hold x, y, frame_count and every pipeline stage while enable=0, with no pulse repeated or lost.
REQ-024 SHALL increment frame_count on the cycle in which x and y both wrap to 0.
REQ-025 SHALL register the stage-0 controls from the current x/y: display = x<H_ACTIVE and y<V_ACTIVE.
REQ-026 SHALL assert hsync for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
REQ-027 SHALL assert vsync for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, independent of x.
REQ-028 SHALL drive the stage-0 controls to the outputs one cycle after the x/y they describe.
REQ-029 SHALL pass the stage-0 controls through a PIPE_DELAY-deep shift register, giving total latency 1+PIPE_DELAY cycles from x/y.
REQ-030 SHALL keep x, y and frame_count undelayed.
REQ-031 SHALL drive VGA_HS = HS_POL when hsync is active and ~HS_POL otherwise; VGA_VS follows VS_POL the same way.

Reset
REQ-032 SHALL, on reset high at a VGA_CLK edge, set x=0, y=0, frame_count=0, displayArea=0, VGA_BLANK_N=0, line_start=0, frame_start=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, and clear every delay stage to the inactive level.
REQ-033 SHALL let reset override enable.
REQ-034 SHALL, when reset occurs mid-frame, restart at x=0,y=0 on the first cycle after release, with no partial-line pulse.

Structure
REQ-035 SHALL keep the default 640x480@60 timing constants and the polarity encoding in a shared package vga_pkg.
REQ-036 SHALL implement the delay line as one sub-module, vga_ctrl_delay, parametrised by DEPTH and WIDTH; at DEPTH 0 it is a passthrough.

Verification
REQ-037 SHALL cover defaults after reset: x reaches 799 then 0, y reaches 524 then 0, and frame_start pulses every 420000 cycles.
REQ-038 SHALL cover sync and display windows at defaults with PIPE_DELAY=0:
- VGA_HS low for exactly 96 cycles, starting 1 cycle after x=656.
- VGA_VS low for exactly 2 lines, starting after y=490.
- displayArea high for 640 cycles per visible line.
REQ-039 SHALL cover PIPE_DELAY=3: every control edge moves 3 cycles later than with PIPE_DELAY=0, while x/y are unchanged.
REQ-040 SHALL cover enable low for 50 cycles at x=700: x, y and the outputs are frozen, and line_start fires exactly once per line.
REQ-041 SHALL cover HS_POL=1, VS_POL=1: after reset both syncs read 0, and they are high during their sync windows.
REQ-042 SHALL cover reset asserted at x=300,y=200: the next cycle after release shows x=0,y=0, frame_count=0, and frame_start pulses after 1+PIPE_DELAY cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, sync polarity encoding and control bundle.
package vga_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam logic POL_ACTIVE_LOW = 1'b0;

    // Controls are carried active-high internally; polarity is applied only at the pins.
    typedef struct packed {
        logic display;
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } ctrl_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: enable input and raster/sync outputs of the VGA timing generator.
interface vga_timing_gen_if #(parameter int CW = 11);
    logic          enable;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          displayArea;
    logic          VGA_HS;
    logic          VGA_VS;
    logic          VGA_BLANK_N;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_count;
    modport master (input enable, output x, y, displayArea, VGA_HS, VGA_VS, VGA_BLANK_N,
                    line_start, frame_start, frame_count);
    modport slave  (output enable, input x, y, displayArea, VGA_HS, VGA_VS, VGA_BLANK_N,
                    line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_ctrl_delay.sv
// vga_ctrl_delay: enable-gated shift register of DEPTH stages; a plain wire at DEPTH 0.
module vga_ctrl_delay #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, rst, en};
        assign q = d;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;
        always_comb begin
            pipe_d = pipe_q;
            if (en) begin
                pipe_d[0] = d;
                for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
            end
        end
        always_ff @(posedge clk) begin
            if (rst) pipe_q <= '0;
            else     pipe_q <= pipe_d;
        end
        assign q = pipe_q[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters with registered, optionally delayed sync/display controls.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = H_ACTIVE_DEF,
    parameter int   H_FP       = H_FP_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BP       = H_BP_DEF,
    parameter int   V_ACTIVE   = V_ACTIVE_DEF,
    parameter int   V_FP       = V_FP_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BP       = V_BP_DEF,
    parameter logic HS_POL     = POL_ACTIVE_LOW,
    parameter logic VS_POL     = POL_ACTIVE_LOW,
    parameter int   PIPE_DELAY = 0,
    parameter int   CW         = 11
) (
    input logic VGA_CLK,
    input logic reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]    fc_q, fc_d;
    ctrl_t         ctrl_q, ctrl_d, ctrl_o;
    logic          adv_q, adv_d;
    logic          x_wrap, y_wrap;

    always_comb begin
        x_wrap = x_q == H_LAST;
        y_wrap = y_q == V_LAST;
        x_d    = vga.enable ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
        y_d    = (vga.enable && x_wrap) ? (y_wrap ? '0 : y_q + 1'b1) : y_q;
        fc_d   = fc_q + {7'd0, vga.enable && x_wrap && y_wrap};
        ctrl_d = vga.enable ? '{display:     x_q < H_VIS && y_q < V_VIS,
                                hsync:       x_q >= HS_BEG && x_q < HS_END,
                                vsync:       y_q >= VS_BEG && y_q < VS_END,
                                line_start:  x_q == '0,
                                frame_start: x_q == '0 && y_q == '0}
                            : ctrl_q;
        adv_d  = vga.enable;
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            fc_q   <= '0;
            ctrl_q <= '0;
            adv_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            fc_q   <= fc_d;
            ctrl_q <= ctrl_d;
            adv_q  <= adv_d;
        end
    end

    vga_ctrl_delay #(.DEPTH(PIPE_DELAY), .WIDTH($bits(ctrl_t))) u_delay (
        .clk(VGA_CLK),
        .rst(reset),
        .en (vga.enable),
        .d  (ctrl_q),
        .q  (ctrl_o)
    );

    // Pulses are qualified by the last edge having advanced, so a stall never stretches them.
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.frame_count = fc_q;
    assign vga.displayArea = ctrl_o.display;
    assign vga.VGA_BLANK_N = ctrl_o.display;
    assign vga.VGA_HS      = sync_level(ctrl_o.hsync, HS_POL);
    assign vga.VGA_VS      = sync_level(ctrl_o.vsync, VS_POL);
    assign vga.line_start  = ctrl_o.line_start & adv_q;
    assign vga.frame_start = ctrl_o.frame_start & adv_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of raster counting, sync windows, pipeline delay, stall and reset.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    int n_run = 0;
    int n_fail = 0;
    int hs_fall0, hs_low0, hs_fall3, hs_low3, hsp_hi;
    int disp_cnt0, disp_last0, disp_cnt3, disp_first3, disp_last3, ls0, ls3;
    int nfs, fs_a, fs_b, vs_low, vs_first, hs_low_s;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(11)) if0 ();
    vga_timing_gen_if #(.CW(11)) if3 ();
    vga_timing_gen_if #(.CW(11)) ifp ();
    vga_timing_gen_if #(.CW(11)) ifs ();
    assign if0.enable = en;
    assign if3.enable = en;
    assign ifp.enable = en;
    assign ifs.enable = en;

    vga_timing_gen dut0 (.VGA_CLK(clk), .reset(rst), .vga(if0));
    vga_timing_gen #(.PIPE_DELAY(3)) dut3 (.VGA_CLK(clk), .reset(rst), .vga(if3));
    vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) dutp (.VGA_CLK(clk), .reset(rst), .vga(ifp));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) duts (.VGA_CLK(clk), .reset(rst), .vga(ifs));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(if0.x), 0);
        chk("rst_y", 32'(if0.y), 0);
        chk("rst_fc", 32'(if0.frame_count), 0);
        chk("rst_disp", 32'(if0.displayArea), 0);
        chk("rst_blank", 32'(if0.VGA_BLANK_N), 0);
        chk("rst_ls", 32'(if0.line_start), 0);
        chk("rst_fs", 32'(if0.frame_start), 0);
        chk("rst_hs", 32'(if0.VGA_HS), 1);
        chk("rst_vs", 32'(if0.VGA_VS), 1);
        chk("rst_hs_pol", 32'(ifp.VGA_HS), 0);
        chk("rst_vs_pol", 32'(ifp.VGA_VS), 0);
        chk("rst_disp3", 32'(if3.displayArea), 0);
        rst = 1'b0;
        {hs_fall0, hs_low0, hs_fall3, hs_low3, hsp_hi} = '0;
        {disp_cnt0, disp_last0, disp_cnt3, disp_first3, disp_last3, ls0, ls3} = '0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("x_k1", 32'(if0.x), 1);
                chk("ls_k1", 32'(if0.line_start), 1);
                chk("fs_k1", 32'(if0.frame_start), 1);
            end
            if (k == 400) chk("x3_k400", 32'(if3.x), 400);
            if (k == 799) chk("x_799", 32'(if0.x), 799);
            if (k == 800) begin
                chk("x_wrap", 32'(if0.x), 0);
                chk("y_step", 32'(if0.y), 1);
                chk("x3_wrap", 32'(if3.x), 0);
            end
            if (!if0.VGA_HS) begin hs_low0++; if (hs_fall0 == 0) hs_fall0 = k; end
            if (!if3.VGA_HS) begin hs_low3++; if (hs_fall3 == 0) hs_fall3 = k; end
            if (ifp.VGA_HS) hsp_hi++;
            if (if0.displayArea) begin disp_cnt0++; disp_last0 = k; end
            if (if3.displayArea) begin disp_cnt3++; disp_last3 = k; if (disp_first3 == 0) disp_first3 = k; end
            ls0 += int'(if0.line_start);
            ls3 += int'(if3.line_start);
        end
        chk("hs_fall0", hs_fall0, 657);
        chk("hs_low0", hs_low0, 96);
        chk("hs_fall3", hs_fall3, 660);
        chk("hs_low3", hs_low3, 96);
        chk("hs_pol_hi", hsp_hi, 96);
        chk("disp_cnt0", disp_cnt0, 640);
        chk("disp_last0", disp_last0, 640);
        chk("disp_cnt3", disp_cnt3, 640);
        chk("disp_first3", disp_first3, 4);
        chk("disp_last3", disp_last3, 643);
        chk("ls_cnt0", ls0, 1);
        chk("ls_cnt3", ls3, 1);
        ls0 = 0;
        repeat (700) begin @(negedge clk); ls0 += int'(if0.line_start); end
        chk("frz_pre_x", 32'(if0.x), 700);
        en = 1'b0;
        repeat (50) begin @(negedge clk); ls0 += int'(if0.line_start); end
        chk("frz_x", 32'(if0.x), 700);
        chk("frz_y", 32'(if0.y), 1);
        chk("frz_hs", 32'(if0.VGA_HS), 0);
        chk("frz_x3", 32'(if3.x), 700);
        chk("frz_hs3", 32'(if3.VGA_HS), 0);
        en = 1'b1;
        repeat (100) begin @(negedge clk); ls0 += int'(if0.line_start); end
        chk("frz_ls_cnt", ls0, 1);
        chk("frz_post_x", 32'(if0.x), 0);
        chk("frz_post_y", 32'(if0.y), 2);
        repeat (300) @(negedge clk);
        chk("mid_x", 32'(if0.x), 300);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_x", 32'(if0.x), 0);
        chk("mid_rst_y", 32'(if0.y), 0);
        chk("mid_rst_fc", 32'(if0.frame_count), 0);
        chk("mid_rst_ls", 32'(if0.line_start), 0);
        chk("mid_rst_fs", 32'(if0.frame_start), 0);
        {nfs, fs_a, fs_b, vs_low, vs_first, hs_low_s} = '0;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk("mid_fs0", 32'(if0.frame_start), 32'(k == 1));
                chk("mid_fs3", 32'(if3.frame_start), 32'(k == 4));
            end
            if (ifs.frame_start) begin
                nfs++;
                if (nfs == 1) fs_a = k;
                if (nfs == 2) fs_b = k;
            end
            if (k <= 120 && !ifs.VGA_VS) begin vs_low++; if (vs_first == 0) vs_first = k; end
            if (k <= 120 && !ifs.VGA_HS) hs_low_s++;
            if (k == 14) chk("s_x14", 32'(ifs.x), 14);
            if (k == 15) begin chk("s_xwrap", 32'(ifs.x), 0); chk("s_y1", 32'(ifs.y), 1); end
            if (k == 119) begin chk("s_y7", 32'(ifs.y), 7); chk("s_fc0", 32'(ifs.frame_count), 0); end
            if (k == 120) begin chk("s_ywrap", 32'(ifs.y), 0); chk("s_fc1", 32'(ifs.frame_count), 1); end
            if (k == 240) chk("s_fc2", 32'(ifs.frame_count), 2);
        end
        chk("s_fs_cnt", nfs, 3);
        chk("s_fs_first", fs_a, 1);
        chk("s_fs_period", fs_b - fs_a, 120);
        chk("s_vs_low", vs_low, 30);
        chk("s_vs_first", vs_first, 76);
        chk("s_hs_low", hs_low_s, 24);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
